if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- IF stage of the P7 pipelined MIPS CPU; it sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and selects the next PC (interrupt vector, eret return, branch/jump target, PC+4).
- Drives a request/acknowledge instruction-memory port and buffers one fetched instruction with its PC, PC+4 and an AdEL flag.
- Honours hazard-unit stalls and squashes wrong-path fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset.
- INT_VEC, 32'h0000_4180, exception/interrupt handler entry.
- IM_LO, 32'h0000_3000, lowest legal instruction address.
- IM_HI, 32'h0000_6FFC, highest legal instruction address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk.
- stall  in  1  hazard unit: IF/ID not accepting; hold buffered instruction.
- int_req  in  1  CP0 interrupt/exception request; redirect to INT_VEC.
- eret  in  1  eret decoded in ID; redirect to epc.
- epc  in  32  CP0 EPC.
- br_taken  in  1  branch/jump resolved taken in ID.
- br_target  in  32  branch/jump target.
- im_req  out  1  instruction-memory request.
- im_addr  out  32  request word address.
- im_ack  in  1  memory returns im_rdata this cycle.
- im_rdata  in  32  instruction word.
- valid_if  out  1  instr_if/pc_if/pc4_if/adel_if hold a fetched instruction.
- instr_if  out  32  instruction; 0 (nop) when adel_if=1.
- pc_if  out  32  PC of instr_if.
- pc4_if  out  32  pc_if + 4 (mod 2^32).
- adel_if  out  1  PC misaligned or outside [IM_LO, IM_HI].

Behaviour:
- Reset (reset=0 at posedge): pc <= RESET_PC; state <= S_REQ; valid_if=0, instr_if=0, pc_if=RESET_PC, pc4_if=RESET_PC+4, adel_if=0. im_req is 0 while reset is low. Reset overrides everything, including a request in flight; a late im_ack after reset is ignored.
- npc priority: int_req -> INT_VEC; else eret&!stall -> epc; else br_taken&!stall -> br_target; else pc+4. eret and br_taken are ignored while stall=1. int_req is honoured regardless of stall.
- redirect = int_req | ((eret|br_taken)&!stall).
- legal(a) = (a[1:0]==0) & IM_LO<=a<=IM_HI.
- S_REQ: pc is pending.
  - If !legal(pc): no im_req. Next cycle valid_if=1, instr_if=0, adel_if=1 -> S_HAVE.
  - Else im_req=1, im_addr=pc. Request and address are held stable until im_ack.
  - On im_ack: capture im_rdata; next cycle valid_if=1, adel_if=0 -> S_HAVE.
  - redirect without im_ack: pc <= npc -> S_DROP.
  - redirect with im_ack: discard data, pc <= npc, stay S_REQ.
- S_HAVE: valid_if=1; outputs show the buffered instruction.
  - stall=1 and no int_req: hold all outputs; im_req=0.
  - stall=0 or redirect: the instruction is consumed (or squashed) this cycle; pc <= npc.
    - If legal(npc): im_req=1, im_addr=npc this same cycle. On im_ack, stay S_HAVE with the new word next cycle, giving one instruction per cycle with zero-wait memory. Without ack -> S_REQ, valid_if=0.
    - If !legal(npc): next cycle S_HAVE with adel_if=1, instr_if=0.
  - An int_req arriving during stall squashes the buffered instruction.
- S_DROP: im_req=1 with the old address held until im_ack. Data is discarded -> S_REQ using the redirected pc.
  - A further redirect in S_DROP updates pc and stays in S_DROP.
- pc4_if always equals pc_if+4, including after eret (EPC+4).
- valid_if never rises in the same cycle as a squash.

Decomposition:
- Shared package cpu_defs: RESET_PC, INT_VEC, IM_LO, IM_HI, EXC_ADEL=5'd4, and the state encoding S_REQ/S_HAVE/S_DROP (2-bit).
- One sub-module, if_npc_sel: combinational npc priority mux plus the legal() check. The FSM and buffer stay in the top.

Test Plan:
- Reset low 2 cycles, then high, zero-wait memory -> im_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; valid_if=1 from cycle 2 with pc_if tracking; pc4_if = pc_if+4.
- stall=1 for 3 cycles while S_HAVE holds pc_if=0x3008 -> outputs frozen, im_req=0; stall drop -> next pc_if=0x300C.
- br_taken=1, br_target=0x3100, memory waits 2 cycles on the old request -> S_DROP, old data discarded, next valid pc_if=0x3100; no 0x300C instruction ever valid.
- int_req pulse during stall=1 with eret=1 -> int wins: pc_if=0x4180 next valid; eret ignored.
- eret with epc=0x3002 -> no im_req; valid_if=1, adel_if=1, instr_if=0, pc_if=0x3002, pc4_if=0x3006.
- reset low while in S_DROP with an ack arriving the same cycle -> outputs return to reset values; next fetch address 0x3000.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared constants for the P7 pipeline front end: address map, exception codes
// and the fetch FSM state encoding.
package cpu_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] INT_VEC  = 32'h0000_4180;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HAVE = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    // Word aligned and inside the instruction memory window.
    function automatic logic im_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= IM_LO) && (a <= IM_HI);
    endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC priority mux (interrupt > eret > branch > pc+4) and the
// instruction-address legality checks for both the current and next PC.
module if_npc_sel
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        int_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] npc,
    output logic        redirect,
    output logic        pc_legal,
    output logic        npc_legal
);

    always_comb begin
        npc = pc + 32'd4;
        if (int_req)
            npc = INT_VEC;
        else if (eret && !stall)
            npc = epc;
        else if (br_taken && !stall)
            npc = br_target;
    end

    // A stalled ID stage cannot act on eret/branch, but interrupts always win.
    assign redirect  = int_req | ((eret | br_taken) & ~stall);
    assign pc_legal  = im_legal(pc);
    assign npc_legal = im_legal(npc);

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, runs the instruction-memory req/ack handshake and
// buffers one fetched instruction for the IF/ID register.
module if_fetch_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        int_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        valid_if,
    output logic [31:0] instr_if,
    output logic [31:0] pc_if,
    output logic [31:0] pc4_if,
    output logic        adel_if,
    output logic [1:0]  dbg_state
);

    // Memory handshake: im_req/im_addr stay constant from the first cycle of a
    // request until the cycle im_ack=1; that cycle transfers im_rdata and ends it.

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drop_addr;
    logic [31:0]  npc;
    logic         redirect;
    logic         pc_legal;
    logic         npc_legal;
    logic         advance;

    if_npc_sel u_npc_sel (
        .pc        (pc),
        .stall     (stall),
        .int_req   (int_req),
        .eret      (eret),
        .epc       (epc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .npc       (npc),
        .redirect  (redirect),
        .pc_legal  (pc_legal),
        .npc_legal (npc_legal)
    );

    assign advance   = ~stall | redirect;
    assign pc4_if    = pc_if + 32'd4;
    assign dbg_state = state;

    always_comb begin
        im_req  = 1'b0;
        im_addr = pc;
        case (state)
            S_REQ:  im_req = pc_legal;
            S_HAVE: begin
                im_req  = advance & npc_legal;
                im_addr = npc;
            end
            S_DROP: begin
                im_req  = 1'b1;
                im_addr = drop_addr;
            end
            default: im_req = 1'b0;
        endcase
        if (!reset)
            im_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            valid_if  <= 1'b0;
            instr_if  <= 32'd0;
            pc_if     <= RESET_PC;
            adel_if   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect) begin
                        pc <= npc;
                        // An unanswered request must still be drained.
                        if (pc_legal && !im_ack) begin
                            drop_addr <= pc;
                            state     <= S_DROP;
                        end
                    end else if (!pc_legal) begin
                        valid_if <= 1'b1;
                        adel_if  <= 1'b1;
                        instr_if <= 32'd0;
                        pc_if    <= pc;
                        state    <= S_HAVE;
                    end else if (im_ack) begin
                        valid_if <= 1'b1;
                        adel_if  <= 1'b0;
                        instr_if <= im_rdata;
                        pc_if    <= pc;
                        state    <= S_HAVE;
                    end
                end
                S_HAVE: begin
                    if (advance) begin
                        pc    <= npc;
                        pc_if <= npc;
                        if (!npc_legal) begin
                            valid_if <= 1'b1;
                            adel_if  <= 1'b1;
                            instr_if <= 32'd0;
                        end else if (im_ack) begin
                            valid_if <= 1'b1;
                            adel_if  <= 1'b0;
                            instr_if <= im_rdata;
                        end else begin
                            valid_if <= 1'b0;
                            adel_if  <= 1'b0;
                            state    <= S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (redirect)
                        pc <= npc;
                    if (im_ack)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
